// File: rtl/bsg_tagged_1_to_n_dispatch.sv
// bsg_tagged_1_to_n_dispatch
// Steers one tagged valid/ready stream into els_p output channels. Each
// channel has a private 2-entry FIFO drained through a valid/yumi handshake,
// so a stalled consumer only back-pressures words addressed to it.
// Optional macro BSG_DISPATCH_TAG_CHECK_EN: out-of-range tags are accepted,
// dropped and flagged on a sticky err_o. Without it, such tags stall the
// producer and err_o is tied low.
module bsg_tagged_1_to_n_dispatch #(
  parameter  int width_p      = 16,
  parameter  int els_p        = 3,
  localparam int tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [tag_width_lp-1:0]  tag_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [els_p*width_p-1:0] data_o,
  output logic [els_p-1:0]         v_o,
  input  logic [els_p-1:0]         yumi_i,
  output logic                     err_o
);

  localparam logic [tag_width_lp:0] els_lp = (tag_width_lp+1)'(els_p);

  // Per-channel storage; data is never reset, only the control state is
  logic [width_p-1:0] mem_r [els_p][2];
  logic [els_p-1:0]   rptr_r;
  logic [els_p-1:0]   wptr_r;
  logic [1:0]         cnt_r [els_p];

  logic               tag_ok;
  logic [els_p-1:0]   enq;
  logic [els_p-1:0]   deq;

  // Channel occupancy and head words
  always_comb begin
    v_o    = '0;
    data_o = '0;
    for (int k = 0; k < els_p; k++) begin
      v_o[k]                       = (cnt_r[k] != 2'd0);
      data_o[k*width_p +: width_p] = mem_r[k][rptr_r[k]];
    end
  end

  // Ready depends only on the addressed channel's fill level
  always_comb begin
    tag_ok = ({1'b0, tag_i} < els_lp);
`ifdef BSG_DISPATCH_TAG_CHECK_EN
    ready_o = 1'b1;
`else
    ready_o = 1'b0;
`endif
    for (int k = 0; k < els_p; k++) begin
      if (tag_i == tag_width_lp'(k)) ready_o = (cnt_r[k] != 2'd2);
    end
  end

  // Per-channel enqueue/dequeue strobes; a yumi on an empty channel is ignored
  always_comb begin
    enq = '0;
    deq = '0;
    for (int k = 0; k < els_p; k++) begin
      enq[k] = v_i & ready_o & ~reset_i & (tag_i == tag_width_lp'(k));
      deq[k] = yumi_i[k] & v_o[k];
    end
  end

  // FIFO control state: pointers and counts
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      for (int k = 0; k < els_p; k++) cnt_r[k] <= 2'd0;
    end else begin
      rptr_r <= rptr_r ^ deq;
      wptr_r <= wptr_r ^ enq;
      for (int k = 0; k < els_p; k++) begin
        cnt_r[k] <= cnt_r[k] + {1'b0, enq[k]} - {1'b0, deq[k]};
      end
    end
  end

  // FIFO data writes
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < els_p; k++) begin
      if (enq[k]) mem_r[k][wptr_r[k]] <= data_i;
    end
  end

`ifdef BSG_DISPATCH_TAG_CHECK_EN
  logic err_r;

  // Sticky flag for words dropped because of an out-of-range tag
  always_ff @(posedge clk_i) begin
    if (reset_i)            err_r <= 1'b0;
    else if (v_i & ~tag_ok) err_r <= 1'b1;
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;

  a_bad_tag: assert property (@(posedge clk_i) disable iff (reset_i)
    !(v_i && !tag_ok));
`endif

  a_yumi_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    ((yumi_i & ~v_o) == '0));

endmodule
